// File: rtl/pinball_pkg.sv
// Shared types and constants for the pinball game flow logic.
package pinball_pkg;

    // Game flow states; encoding is visible on the debug/LED state output.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PLAY   = 3'd1,
        PAUSED = 3'd2,
        LOST   = 3'd3,
        OVER   = 3'd4
    } game_state_t;

    // Highest displayable score; the counter holds here instead of wrapping.
    localparam logic [7:0] SCORE_MAX_BCD = 8'h99;

    // Two-digit BCD increment that saturates at SCORE_MAX_BCD.
    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] value);
        logic [7:0] result;
        if (value == SCORE_MAX_BCD) begin
            result = value;
        end else if (value[3:0] == 4'd9) begin
            result = {value[7:4] + 4'd1, 4'd0};
        end else begin
            result = {value[7:4], value[3:0] + 4'd1};
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit saturating BCD counter with synchronous clear and increment enable.
module bcd_counter2
    import pinball_pkg::*;
(
    input  logic       clk,
    input  logic       resetN,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [7:0] count_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Clear has priority over increment; saturation lives in the helper.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = 8'h00;
        end else if (inc_i) begin
            count_d = bcd_inc_sat(count_q);
        end
    end

    // Score register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count_q <= 8'h00;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/game_sequencer.sv
// Frame-level pinball game flow: ball lifecycle FSM, lives, BCD score and
// the pause/ball-reset/launch controls for the moving objects.
module game_sequencer
    import pinball_pkg::*;
#(
    parameter int LIVES_INIT        = 3,
    parameter int LOST_DELAY_FRAMES = 60
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       collisionSmileyFlipper,
    input  logic       collisionSmileyBottom,
    input  logic       key5IsPressed,
    input  logic       keyPIsPressed,
    output logic       pause,
    output logic       ballReset,
    output logic       launch,
    output logic       gameOver,
    output logic [1:0] lives,
    output logic [7:0] scoreBCD,
    output logic [2:0] state
);

    localparam logic [1:0] LIVES_RESET = 2'(LIVES_INIT);
    // The dwell ends on the pulse that arrives while the counter holds N-1.
    localparam logic [7:0] LOST_LAST   = 8'(LOST_DELAY_FRAMES - 1);

    // Key synchronisers and rise detectors.
    logic key5_q, key5_d_q, key5_rise_q;
    logic keyp_q, keyp_d_q, keyp_rise_q;

    // Per-frame collision memory.
    logic flip_hit_q, bottom_hit_q;

    // FSM state and registered outputs.
    game_state_t state_q;
    logic [1:0]  lives_q;
    logic [7:0]  frame_cnt_q;
    logic        pause_q, ball_reset_q, launch_q, game_over_q;

    logic       score_inc, score_clr;
    logic [7:0] score_bcd;

    // Register keys, then register their rising edges. The previous-value
    // registers reset to 1 so a key held through reset never fires.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            key5_q      <= 1'b1;
            key5_d_q    <= 1'b1;
            key5_rise_q <= 1'b0;
            keyp_q      <= 1'b1;
            keyp_d_q    <= 1'b1;
            keyp_rise_q <= 1'b0;
        end else begin
            key5_q      <= key5IsPressed;
            key5_d_q    <= key5_q;
            key5_rise_q <= key5_q & ~key5_d_q;
            keyp_q      <= keyPIsPressed;
            keyp_d_q    <= keyp_q;
            keyp_rise_q <= keyp_q & ~keyp_d_q;
        end
    end

    // Remember any collision within the frame; forget it at each frame start.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            flip_hit_q   <= 1'b0;
            bottom_hit_q <= 1'b0;
        end else if (startOfFrame) begin
            flip_hit_q   <= 1'b0;
            bottom_hit_q <= 1'b0;
        end else begin
            flip_hit_q   <= flip_hit_q | collisionSmileyFlipper;
            bottom_hit_q <= bottom_hit_q | collisionSmileyBottom;
        end
    end

    // Score commits only at a frame boundary while playing; a restart from
    // game over zeroes it.
    assign score_inc = (state_q == PLAY) && startOfFrame && flip_hit_q;
    assign score_clr = (state_q == OVER) && key5_rise_q;

    bcd_counter2 u_score (
        .clk     (clk),
        .resetN  (resetN),
        .clr_i   (score_clr),
        .inc_i   (score_inc),
        .count_o (score_bcd)
    );

    // Game flow FSM; outputs are updated together with the state transition.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= IDLE;
            lives_q      <= LIVES_RESET;
            frame_cnt_q  <= 8'd0;
            pause_q      <= 1'b1;
            ball_reset_q <= 1'b1;
            launch_q     <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            launch_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (key5_rise_q) begin
                        state_q      <= PLAY;
                        launch_q     <= 1'b1;
                        pause_q      <= 1'b0;
                        ball_reset_q <= 1'b0;
                    end
                end
                PLAY: begin
                    // A loss at the frame commit wins over a pause request.
                    if (startOfFrame && bottom_hit_q && (lives_q != 2'd0)) begin
                        lives_q      <= lives_q - 2'd1;
                        frame_cnt_q  <= 8'd0;
                        state_q      <= LOST;
                        pause_q      <= 1'b1;
                        ball_reset_q <= 1'b1;
                    end else if (keyp_rise_q) begin
                        state_q <= PAUSED;
                        pause_q <= 1'b1;
                    end
                end
                PAUSED: begin
                    if (keyp_rise_q) begin
                        state_q <= PLAY;
                        pause_q <= 1'b0;
                    end
                end
                LOST: begin
                    if (startOfFrame) begin
                        if (frame_cnt_q == LOST_LAST) begin
                            if (lives_q == 2'd0) begin
                                state_q     <= OVER;
                                game_over_q <= 1'b1;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                        end
                    end
                end
                OVER: begin
                    if (key5_rise_q) begin
                        state_q     <= IDLE;
                        lives_q     <= LIVES_RESET;
                        game_over_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    pause_q      <= 1'b1;
                    ball_reset_q <= 1'b1;
                    game_over_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pause     = pause_q;
    assign ballReset = ball_reset_q;
    assign launch    = launch_q;
    assign gameOver  = game_over_q;
    assign lives     = lives_q;
    assign scoreBCD  = score_bcd;
    assign state     = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: stimulus pushes every expected output
// change (with its cycle) into a queue; a negedge monitor pops on each change.
module tb_game_sequencer;
    import pinball_pkg::*;

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] lv;
        logic [7:0] sc;
        logic       ps;
        logic       br;
        logic       ln;
        logic       go;
    } snap_t;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic       collisionSmileyFlipper;
    logic       collisionSmileyBottom;
    logic       key5IsPressed;
    logic       keyPIsPressed;
    logic       pause, ballReset, launch, gameOver;
    logic [1:0] lives;
    logic [7:0] scoreBCD;
    logic [2:0] state;

    int    cyc   = 0;
    int    n_cmp = 0;
    int    n_bad = 0;
    snap_t exp_q[$];
    int    cyc_q[$];

    game_sequencer #(
        .LIVES_INIT        (3),
        .LOST_DELAY_FRAMES (2)
    ) dut (
        .clk                    (clk),
        .resetN                 (resetN),
        .startOfFrame           (startOfFrame),
        .collisionSmileyFlipper (collisionSmileyFlipper),
        .collisionSmileyBottom  (collisionSmileyBottom),
        .key5IsPressed          (key5IsPressed),
        .keyPIsPressed          (keyPIsPressed),
        .pause                  (pause),
        .ballReset              (ballReset),
        .launch                 (launch),
        .gameOver               (gameOver),
        .lives                  (lives),
        .scoreBCD               (scoreBCD),
        .state                  (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic snap_t mk(input logic [2:0] st, input logic [1:0] lv,
                                 input logic [7:0] sc, input logic ps,
                                 input logic br, input logic ln, input logic go);
        snap_t s;
        s.st = st; s.lv = lv; s.sc = sc; s.ps = ps; s.br = br; s.ln = ln; s.go = go;
        return s;
    endfunction

    task automatic push_exp(input snap_t e, input int c);
        exp_q.push_back(e);
        cyc_q.push_back(c);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame: collisions for len cycles, then a startOfFrame pulse.
    // kp places a keyP press so its registered rise lands on the commit edge.
    task automatic frame(input bit flip, input bit bot, input int len,
                         input bit kp, input bit has_exp, input snap_t e);
        for (int i = 0; i < len; i++) begin
            tick();
            collisionSmileyFlipper = flip;
            collisionSmileyBottom  = bot;
            if (kp && i == len - 2) keyPIsPressed = 1'b1;
        end
        tick();
        collisionSmileyFlipper = 1'b0;
        collisionSmileyBottom  = 1'b0;
        startOfFrame = 1'b1;
        if (has_exp) push_exp(e, cyc + 1);
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic launch_game(input logic [1:0] lv, input logic [7:0] sc);
        tick();
        key5IsPressed = 1'b1;
        push_exp(mk(PLAY, lv, sc, 1'b0, 1'b0, 1'b1, 1'b0), cyc + 3);
        push_exp(mk(PLAY, lv, sc, 1'b0, 1'b0, 1'b0, 1'b0), cyc + 4);
        repeat (6) tick();
        key5IsPressed = 1'b0;
        repeat (2) tick();
    endtask

    task automatic lost_dwell(input snap_t e);
        frame(1'b0, 1'b0, 4, 1'b0, 1'b0, e);
        frame(1'b0, 1'b0, 4, 1'b0, 1'b1, e);
    endtask

    // Monitor: every change of the output vector is one transaction.
    initial begin
        snap_t cur, prev, e;
        int    ec;
        prev = '1;
        forever begin
            @(negedge clk);
            cur = {state, lives, scoreBCD, pause, ballReset, launch, gameOver};
            if (cur !== prev) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_change: got %h at cycle %0d, required no change", cur, cyc);
                end else begin
                    e  = exp_q.pop_front();
                    ec = cyc_q.pop_front();
                    if (cur !== e || (ec >= 0 && ec != cyc)) begin
                        n_bad++;
                        $display("FAIL out_seq: got st=%0d lv=%0d sc=%h ps=%b br=%b ln=%b go=%b @%0d, required st=%0d lv=%0d sc=%h ps=%b br=%b ln=%b go=%b @%0d",
                                 cur.st, cur.lv, cur.sc, cur.ps, cur.br, cur.ln, cur.go, cyc,
                                 e.st, e.lv, e.sc, e.ps, e.br, e.ln, e.go, ec);
                    end else begin
                        $display("txn %0d ok: st=%0d lv=%0d sc=%h ps=%b br=%b ln=%b go=%b @%0d",
                                 n_cmp, cur.st, cur.lv, cur.sc, cur.ps, cur.br, cur.ln, cur.go, cyc);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        snap_t none;
        logic [3:0] tt, uu;
        none = '0;
        resetN = 1'b0;
        startOfFrame = 1'b0;
        collisionSmileyFlipper = 1'b0;
        collisionSmileyBottom = 1'b0;
        key5IsPressed = 1'b1;            // held through reset: must not launch
        keyPIsPressed = 1'b0;
        push_exp(mk(IDLE, 2'd3, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0), -1);
        repeat (3) tick();
        resetN = 1'b1;
        repeat (4) tick();
        key5IsPressed = 1'b0;
        repeat (3) tick();

        // Game 1: launch, three long frames of flipper contact.
        launch_game(2'd3, 8'h00);
        frame(1'b1, 1'b0, 66, 1'b0, 1'b1, mk(PLAY, 2'd3, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0));
        frame(1'b1, 1'b0, 66, 1'b0, 1'b1, mk(PLAY, 2'd3, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0));
        frame(1'b1, 1'b0, 66, 1'b0, 1'b1, mk(PLAY, 2'd3, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int k = 4; k <= 9; k++)
            frame(1'b1, 1'b0, 4, 1'b0, 1'b1, mk(PLAY, 2'd3, 8'(k), 1'b0, 1'b0, 1'b0, 1'b0));
        frame(1'b1, 1'b0, 4, 1'b0, 1'b1, mk(PLAY, 2'd3, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int t = 1; t <= 9; t++) begin
            for (int u = (t == 1) ? 1 : 0; u <= 9; u++) begin
                tt = 4'(t);
                uu = 4'(u);
                frame(1'b1, 1'b0, 4, 1'b0, 1'b1, mk(PLAY, 2'd3, {tt, uu}, 1'b0, 1'b0, 1'b0, 1'b0));
            end
        end
        // Saturated at 99: further hits produce no output change.
        frame(1'b1, 1'b0, 4, 1'b0, 1'b0, none);
        frame(1'b1, 1'b0, 4, 1'b0, 1'b0, none);

        // Lose all three balls.
        frame(1'b0, 1'b1, 4, 1'b0, 1'b1, mk(LOST, 2'd2, 8'h99, 1'b1, 1'b1, 1'b0, 1'b0));
        lost_dwell(mk(IDLE, 2'd2, 8'h99, 1'b1, 1'b1, 1'b0, 1'b0));
        launch_game(2'd2, 8'h99);
        frame(1'b0, 1'b1, 4, 1'b0, 1'b1, mk(LOST, 2'd1, 8'h99, 1'b1, 1'b1, 1'b0, 1'b0));
        lost_dwell(mk(IDLE, 2'd1, 8'h99, 1'b1, 1'b1, 1'b0, 1'b0));
        launch_game(2'd1, 8'h99);
        frame(1'b0, 1'b1, 4, 1'b0, 1'b1, mk(LOST, 2'd0, 8'h99, 1'b1, 1'b1, 1'b0, 1'b0));
        lost_dwell(mk(OVER, 2'd0, 8'h99, 1'b1, 1'b1, 1'b0, 1'b1));

        // Restart from game over: back to IDLE, no launch.
        tick();
        key5IsPressed = 1'b1;
        push_exp(mk(IDLE, 2'd3, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0), cyc + 3);
        repeat (6) tick();
        key5IsPressed = 1'b0;
        repeat (3) tick();

        // Game 2: score 05, then flipper + bottom + keyP on one commit.
        launch_game(2'd3, 8'h00);
        for (int k = 1; k <= 5; k++)
            frame(1'b1, 1'b0, 4, 1'b0, 1'b1, mk(PLAY, 2'd3, 8'(k), 1'b0, 1'b0, 1'b0, 1'b0));
        frame(1'b1, 1'b1, 4, 1'b1, 1'b1, mk(LOST, 2'd2, 8'h06, 1'b1, 1'b1, 1'b0, 1'b0));
        keyPIsPressed = 1'b0;
        lost_dwell(mk(IDLE, 2'd2, 8'h06, 1'b1, 1'b1, 1'b0, 1'b0));
        launch_game(2'd2, 8'h06);

        // Pause with keyP held >1000 cycles; collisions must be ignored.
        tick();
        keyPIsPressed = 1'b1;
        push_exp(mk(PAUSED, 2'd2, 8'h06, 1'b1, 1'b0, 1'b0, 1'b0), cyc + 3);
        repeat (100) frame(1'b1, 1'b1, 10, 1'b0, 1'b0, none);
        keyPIsPressed = 1'b0;
        repeat (3) tick();
        keyPIsPressed = 1'b1;
        push_exp(mk(PLAY, 2'd2, 8'h06, 1'b0, 1'b0, 1'b0, 1'b0), cyc + 3);
        repeat (4) tick();
        keyPIsPressed = 1'b0;
        repeat (2) tick();
        frame(1'b1, 1'b0, 4, 1'b0, 1'b1, mk(PLAY, 2'd2, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0));
        frame(1'b0, 1'b1, 4, 1'b0, 1'b1, mk(LOST, 2'd1, 8'h07, 1'b1, 1'b1, 1'b0, 1'b0));
        frame(1'b0, 1'b0, 4, 1'b0, 1'b0, none);

        // Asynchronous reset in the middle of the LOST dwell.
        repeat (2) tick();
        push_exp(mk(IDLE, 2'd3, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0), cyc);
        resetN = 1'b0;
        repeat (3) tick();
        resetN = 1'b1;
        repeat (5) tick();
        launch_game(2'd3, 8'h00);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        repeat (10) tick();
        while (exp_q.size() != 0) begin
            snap_t e;
            int    ec;
            e  = exp_q.pop_front();
            ec = cyc_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_change: got no output change, required st=%0d lv=%0d sc=%h @%0d",
                     e.st, e.lv, e.sc, ec);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
